csat_enum_ctrl: RTL and testbench

Exhaustive-search sequencer for the combinational CSAT benchmark circuits. It drives every assignment of the benchmark's primary inputs in turn, one per cycle, and pipelines the candidate alongside the circuit's `sat` result. It stops on the first satisfying assignment or after the whole space has been tried. It is the on-FPGA baseline solver and the harness the team uses to check each benchmark netlist against its expected SAT/UNSAT label.

---
 rtl/csat_enum_pkg.sv | 23 ++
 rtl/csat_tag_pipe.sv | 43 ++++
 rtl/csat_enum_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_csat_enum_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/csat_enum_pkg.sv
// Shared definitions for the CSAT exhaustive-search sequencer.
// Optional build macro: CSAT_ENUM_GRAY_EN (Gray-order candidate walk).
package csat_enum_pkg;

  // Default benchmark input width and sat-path latency.
  localparam int CSAT_N_VARS_DEF   = 8;
  localparam int CSAT_PIPE_LAT_DEF = 1;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Binary-to-Gray conversion.  It works on a 32-bit container; callers
  // size-cast the result back to their own width.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/csat_tag_pipe.sv
// Valid-plus-candidate shift register that keeps each issued candidate
// aligned with the benchmark's delayed sat result.  Flush clears every
// stage in the same clock, so a new search never sees stale tags.
module csat_tag_pipe
  import csat_enum_pkg::*;
#(
  parameter int W     = CSAT_N_VARS_DEF,
  parameter int DEPTH = CSAT_PIPE_LAT_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_cand,
  output logic         tail_valid,
  output logic [W-1:0] tail_cand
);

  logic [DEPTH-1:0]        valid_r;
  logic [DEPTH-1:0][W-1:0] cand_r;

  // Shift tags one stage per clock; flush empties the whole pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= {DEPTH{1'b0}};
      cand_r  <= {(DEPTH*W){1'b0}};
    end else if (flush) begin
      valid_r <= {DEPTH{1'b0}};
      cand_r  <= {(DEPTH*W){1'b0}};
    end else begin
      valid_r[0] <= in_valid;
      cand_r[0]  <= in_cand;
      for (int i = 1; i < DEPTH; i++) begin
        valid_r[i] <= valid_r[i-1];
        cand_r[i]  <= cand_r[i-1];
      end
    end
  end

  assign tail_valid = valid_r[DEPTH-1];
  assign tail_cand  = cand_r[DEPTH-1];

endmodule

// File: rtl/csat_enum_ctrl.sv
// Exhaustive-search sequencer: walks every assignment of the benchmark
// inputs one per cycle, pairs each with its delayed sat result and stops
// on the first satisfying assignment or after the full space is tried.
// Optional build macro: CSAT_ENUM_GRAY_EN -- candidates follow Gray order
// (assign_o = idx ^ (idx >> 1)); otherwise binary order (assign_o = idx).
module csat_enum_ctrl
  import csat_enum_pkg::*;
#(
  parameter int N_VARS   = CSAT_N_VARS_DEF,
  parameter int PIPE_LAT = CSAT_PIPE_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [N_VARS-1:0] assign_o,
  input  logic              sat_i,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [N_VARS-1:0] solution,
  output logic [N_VARS:0]   tried_count
);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [N_VARS-1:0] idx_r;
  logic [N_VARS-1:0] idx_inc_s;
  logic [N_VARS-1:0] next_assign_s;
  logic [3:0]        drain_cnt_r;

  logic              tail_valid_s;
  logic [N_VARS-1:0] tail_cand_s;

  logic              in_search_s;
  logic              start_ok_s;
  logic              eval_s;
  logic              hit_s;
  logic              last_s;
  logic              expire_s;
  logic              flush_s;
  logic              push_s;
  logic              busy_nxt_s;
  logic              done_nxt_s;

  // ---------------------------------------------------------------------
  // Qualifiers
  // ---------------------------------------------------------------------
  assign in_search_s = (state_r == RUN) || (state_r == DRAIN);
  // abort outranks start, and start is only honoured when not searching
  assign start_ok_s  = start && !abort && ((state_r == IDLE) || (state_r == DONE));
  // sat_i only means something when the tail carries a RUN-issued candidate
  assign eval_s      = in_search_s && tail_valid_s;
  assign hit_s       = eval_s && sat_i;
  assign last_s      = (state_r == RUN) && (&idx_r);
  // DRAIN lasts PIPE_LAT+1 cycles: PIPE_LAT to collect the in-flight
  // results, plus the cycle in which the empty tail is observed
  assign expire_s    = (state_r == DRAIN) && (drain_cnt_r == 4'(PIPE_LAT));
  // a hit discards every later in-flight result
  assign flush_s     = abort || start_ok_s || hit_s;
  assign push_s      = (state_r == RUN) && !hit_s;

  assign idx_inc_s   = idx_r + {{(N_VARS-1){1'b0}}, 1'b1};

`ifdef CSAT_ENUM_GRAY_EN
  assign next_assign_s = N_VARS'(bin2gray(32'(idx_inc_s)));
`else
  assign next_assign_s = idx_inc_s;
`endif

  // ---------------------------------------------------------------------
  // Tag pipeline
  // ---------------------------------------------------------------------
  csat_tag_pipe #(
    .W     (N_VARS),
    .DEPTH (PIPE_LAT)
  ) u_tag_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush_s),
    .in_valid   (push_s),
    .in_cand    (assign_o),
    .tail_valid (tail_valid_s),
    .tail_cand  (tail_cand_s)
  );

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state selection; abort wins over every other request.
  always_comb begin
    state_nxt_s = state_r;
    if (abort) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_ok_s) begin
            state_nxt_s = RUN;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        RUN: begin
          if (hit_s) begin
            state_nxt_s = DONE;
          end else if (last_s) begin
            state_nxt_s = DRAIN;
          end else begin
            state_nxt_s = RUN;
          end
        end
        DRAIN: begin
          if (hit_s || expire_s) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = DRAIN;
          end
        end
        DONE: begin
          if (start_ok_s) begin
            state_nxt_s = RUN;
          end else begin
            state_nxt_s = DONE;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // Status decode from the upcoming state so busy/done can be registered.
  always_comb begin
    busy_nxt_s = 1'b0;
    done_nxt_s = 1'b0;
    case (state_nxt_s)
      IDLE: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
      end
      RUN, DRAIN: begin
        busy_nxt_s = 1'b1;
        done_nxt_s = 1'b0;
      end
      DONE: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b1;
      end
      default: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
      end
    endcase
  end

  // Registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_nxt_s;
      done <= done_nxt_s;
    end
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------

  // Candidate issue, drain timer and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r       <= {N_VARS{1'b0}};
      assign_o    <= {N_VARS{1'b0}};
      drain_cnt_r <= 4'd0;
      found       <= 1'b0;
      solution    <= {N_VARS{1'b0}};
      tried_count <= {(N_VARS+1){1'b0}};
    end else if (abort || start_ok_s) begin
      // both return the walk to candidate 0 and clear the previous result;
      // after abort this is the idle value, after start it is candidate 0
      idx_r       <= {N_VARS{1'b0}};
      assign_o    <= {N_VARS{1'b0}};
      drain_cnt_r <= 4'd0;
      found       <= 1'b0;
      solution    <= {N_VARS{1'b0}};
      tried_count <= {(N_VARS+1){1'b0}};
    end else begin
      if (eval_s) begin
        tried_count <= tried_count + {{N_VARS{1'b0}}, 1'b1};
      end else begin
        tried_count <= tried_count;
      end

      if (hit_s) begin
        found    <= 1'b1;
        solution <= tail_cand_s;
      end else begin
        found    <= found;
        solution <= solution;
      end

      // advance only while more candidates remain; assign_o holds otherwise
      if ((state_r == RUN) && !hit_s && !last_s) begin
        idx_r    <= idx_inc_s;
        assign_o <= next_assign_s;
      end else begin
        idx_r    <= idx_r;
        assign_o <= assign_o;
      end

      if (state_r == DRAIN) begin
        drain_cnt_r <= drain_cnt_r + 4'd1;
      end else begin
        drain_cnt_r <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_csat_enum_ctrl.sv
// Directed bench for csat_enum_ctrl with N_VARS=8, PIPE_LAT=2.  The
// benchmark model answers sat for assignment 8'hA5, two cycles late.
// Expectations follow the build: CSAT_ENUM_GRAY_EN selects Gray order.
module tb_csat_enum_ctrl;

  localparam int NV = 8;
  localparam int PL = 2;

`ifdef CSAT_ENUM_GRAY_EN
  localparam int        EXP_TRIED = 199;   // Gray index 0xC6 -> 0xA5
  localparam int        EXP_LAT   = 201;   // 1 + 198 + PIPE_LAT
  localparam logic [7:0] EXP_LAST = 8'h80; // Gray code of 0xFF
  localparam logic [7:0] EXP_C1   = 8'h01;
`else
  localparam int        EXP_TRIED = 166;
  localparam int        EXP_LAT   = 168;
  localparam logic [7:0] EXP_LAST = 8'hFF;
  localparam logic [7:0] EXP_C1   = 8'h01;
`endif
  localparam int UNSAT_LAT = 259;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [NV-1:0] assign_o;
  logic          sat_i;
  logic          busy;
  logic          done;
  logic          found;
  logic [NV-1:0] solution;
  logic [NV:0]   tried_count;

  int checks;
  int errors;

  // benchmark model state
  int         mode;      // 0: hit on 0xA5, 1: tied 0, 2: 1 outside valid tail cycles
  logic [7:0] d1, d2;
  int         tick;
  int         k_tick;
  int         diff;

  csat_enum_ctrl #(
    .N_VARS   (NV),
    .PIPE_LAT (PL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .assign_o    (assign_o),
    .sat_i       (sat_i),
    .busy        (busy),
    .done        (done),
    .found       (found),
    .solution    (solution),
    .tried_count (tried_count)
  );

  always #5 clk = ~clk;

  // two-cycle delay of the candidate plus a free-running cycle counter
  always @(posedge clk) begin
    d1   <= assign_o;
    d2   <= d1;
    tick <= tick + 1;
  end

  always_comb begin
    diff  = tick - k_tick;
    sat_i = 1'b0;
    case (mode)
      0:       sat_i = (d2 == 8'hA5);
      1:       sat_i = 1'b0;
      2:       sat_i = !((diff >= 2) && (diff <= 257));
      default: sat_i = 1'b0;
    endcase
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    k_tick = tick;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (done !== 1'b1 && n < budget);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (assign_o !== 8'h00) begin errors++; $display("FAIL reset_assign got %h exp 00", assign_o); end
    checks++; if (tried_count !== 9'd0) begin errors++; $display("FAIL reset_tried got %0d exp 0", tried_count); end
    checks++; if ({found, solution} !== 9'd0) begin errors++; $display("FAIL reset_result got %b/%h exp 0/00", found, solution); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_start got busy %b exp 0", busy); end
  endtask

  task automatic test_sat_search();
    int n;
    int bad;
    logic [7:0] prev;
    logic       prev_busy;
    mode = 0;
    pulse_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL run_busy got %b exp 1", busy); end
    checks++; if (assign_o !== 8'h00) begin errors++; $display("FAIL cand0 got %h exp 00", assign_o); end
    n = 0; bad = 0;
    prev = assign_o; prev_busy = busy;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        checks++; if (assign_o !== EXP_C1) begin errors++; $display("FAIL cand1 got %h exp %h", assign_o, EXP_C1); end
      end
      if (busy && prev_busy) begin
`ifdef CSAT_ENUM_GRAY_EN
        if ($countones(assign_o ^ prev) != 1) bad++;
`else
        if (assign_o !== prev + 8'd1) bad++;
`endif
      end
      prev = assign_o; prev_busy = busy;
    end while (done !== 1'b1 && n < 400);
    checks++; if (bad != 0) begin errors++; $display("FAIL walk_order got %0d bad steps exp 0", bad); end
    checks++; if (n != EXP_LAT) begin errors++; $display("FAIL hit_latency got %0d exp %0d", n, EXP_LAT); end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL hit_found got %b exp 1", found); end
    checks++; if (solution !== 8'hA5) begin errors++; $display("FAIL hit_solution got %h exp a5", solution); end
    checks++; if (tried_count !== 9'(EXP_TRIED)) begin errors++; $display("FAIL hit_tried got %0d exp %0d", tried_count, EXP_TRIED); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hit_busy got %b exp 0", busy); end
  endtask

  task automatic test_unsat(input int m);
    int n;
    int bad;
    mode = m;
    pulse_start();
    n = 0; bad = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n >= 256 && assign_o !== EXP_LAST) bad++;
    end while (done !== 1'b1 && n < 400);
    repeat (3) begin
      @(posedge clk);
      #1;
      if (assign_o !== EXP_LAST) bad++;
    end
    checks++; if (n != UNSAT_LAT) begin errors++; $display("FAIL unsat%0d_latency got %0d exp %0d", m, n, UNSAT_LAT); end
    checks++; if (found !== 1'b0) begin errors++; $display("FAIL unsat%0d_found got %b exp 0", m, found); end
    checks++; if (tried_count !== 9'd256) begin errors++; $display("FAIL unsat%0d_tried got %0d exp 256", m, tried_count); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL unsat%0d_done got %b exp 1", m, done); end
    checks++; if (bad != 0) begin errors++; $display("FAIL unsat%0d_hold got %0d bad cycles exp 0", m, bad); end
    mode = 0;
    k_tick = tick + 100000;
  endtask

  task automatic test_abort();
    int n;
    mode = 0;
    pulse_start();
    repeat (49) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
    checks++; if (assign_o !== 8'h00) begin errors++; $display("FAIL abort_assign got %h exp 00", assign_o); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b exp 0", done); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_stays_idle got %b exp 0", busy); end
    pulse_start();
    wait_done(400, n);
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL start_abort_state got busy/done %b%b exp 00", busy, done); end
    checks++; if (assign_o !== 8'h00) begin errors++; $display("FAIL start_abort_assign got %h exp 00", assign_o); end
  endtask

  task automatic test_reset_mid();
    int n;
    mode = 0;
    pulse_start();
    repeat (30) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, done, found} !== 3'b000) begin errors++; $display("FAIL async_rst_flags got %b exp 000", {busy, done, found}); end
    checks++; if (assign_o !== 8'h00) begin errors++; $display("FAIL async_rst_assign got %h exp 00", assign_o); end
    checks++; if (tried_count !== 9'd0) begin errors++; $display("FAIL async_rst_tried got %0d exp 0", tried_count); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_rst_idle got %b exp 0", busy); end
    pulse_start();
    wait_done(400, n);
    checks++; if (n != EXP_LAT) begin errors++; $display("FAIL post_rst_latency got %0d exp %0d", n, EXP_LAT); end
    checks++; if (solution !== 8'hA5) begin errors++; $display("FAIL post_rst_solution got %h exp a5", solution); end
  endtask

  task automatic test_back_to_back();
    int m;
    int n;
    mode = 0;
    pulse_start();
    repeat (20) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(400, m);
    checks++; if (21 + m != EXP_LAT) begin errors++; $display("FAIL busy_start_latency got %0d exp %0d", 21 + m, EXP_LAT); end
    checks++; if (tried_count !== 9'(EXP_TRIED)) begin errors++; $display("FAIL busy_start_tried got %0d exp %0d", tried_count, EXP_TRIED); end
    pulse_start();
    checks++; if ({busy, done, found} !== 3'b100) begin errors++; $display("FAIL restart_flags got %b exp 100", {busy, done, found}); end
    checks++; if (tried_count !== 9'd0) begin errors++; $display("FAIL restart_tried_clr got %0d exp 0", tried_count); end
    checks++; if (assign_o !== 8'h00) begin errors++; $display("FAIL restart_cand0 got %h exp 00", assign_o); end
    wait_done(400, n);
    checks++; if (n != EXP_LAT) begin errors++; $display("FAIL restart_latency got %0d exp %0d", n, EXP_LAT); end
    checks++; if ({found, solution} !== {1'b1, 8'hA5}) begin errors++; $display("FAIL restart_result got %b/%h exp 1/a5", found, solution); end
    checks++; if (tried_count !== 9'(EXP_TRIED)) begin errors++; $display("FAIL restart_tried got %0d exp %0d", tried_count, EXP_TRIED); end
  endtask

  initial begin
    clk    = 1'b0;
    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    mode   = 0;
    tick   = 0;
    k_tick = 1000000;
    d1     = 8'h00;
    d2     = 8'h00;
    checks = 0;
    errors = 0;

    test_reset();
    test_sat_search();
    test_unsat(1);
    test_unsat(2);
    test_abort();
    test_reset_mid();
    test_back_to_back();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
